// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file dump block.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package regfile_pkg;

    localparam int REGFILE_WORD_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEND   = 2'd1,
        ST_FINISH = 2'd2
    } state_e;

    // One extra bit beyond $clog2 so the index can also name a word one past
    // the last register (the optional checksum slot).
    function automatic int idx_w(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/regfile_word_mux.sv
// Word-select multiplexer: picks one 32-bit word out of a flat buffer.
// Latency: purely combinational.
// Backpressure: none.
// Ports: flat_i  - flat buffer, word i at [i*32 +: 32]
//        index_i - word index; values >= REG_FILE_SIZE select 0
//        word_o  - selected word
module regfile_word_mux
    import regfile_pkg::*;
#(
    parameter int REG_FILE_SIZE = 8,
    parameter int IDX_W         = idx_w(REG_FILE_SIZE)
) (
    input  logic [REGFILE_WORD_W*REG_FILE_SIZE-1:0] flat_i,
    input  logic [IDX_W-1:0]                        index_i,
    output logic [REGFILE_WORD_W-1:0]               word_o
);

    always_comb begin
        word_o = '0;
        for (int i = 0; i < REG_FILE_SIZE; i++) begin
            if (index_i == IDX_W'(i)) begin
                word_o = flat_i[i*REGFILE_WORD_W +: REGFILE_WORD_W];
            end
        end
    end

endmodule

// File: rtl/regfile_dump.sv
// Captures a flat register snapshot on start and streams it out one word per handshake.
// Latency: first word valid one cycle after start is sampled; done pulses one cycle after the last handshake.
// Backpressure: out_ready low holds out_data/out_index/out_last stable; start is ignored unless idle.
// Ports: clk, reset (async active-high), start, snap_flat (word i at [i*32 +: 32]),
//        out_ready / out_valid / out_data / out_index / out_last (word stream), busy, done.
// Build option: REGFILE_DUMP_CHECKSUM_EN appends the XOR of all buffered words at
//               out_index = REG_FILE_SIZE; that word then carries out_last.
module regfile_dump
    import regfile_pkg::*;
#(
    parameter int REG_FILE_SIZE = 8
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    start,
    input  logic [REGFILE_WORD_W*REG_FILE_SIZE-1:0] snap_flat,
    input  logic                                    out_ready,
    output logic                                    out_valid,
    output logic [REGFILE_WORD_W-1:0]               out_data,
    output logic [$clog2(REG_FILE_SIZE):0]          out_index,
    output logic                                    out_last,
    output logic                                    busy,
    output logic                                    done
);

    localparam int IDX_W = idx_w(REG_FILE_SIZE);

`ifdef REGFILE_DUMP_CHECKSUM_EN
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(REG_FILE_SIZE);
`else
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(REG_FILE_SIZE - 1);
`endif

    state_e                                  state_q, state_d;
    logic [IDX_W-1:0]                        idx_q, idx_d;
    logic [REGFILE_WORD_W*REG_FILE_SIZE-1:0] buf_q, buf_d;

    logic                      in_send;
    logic                      at_last;
    logic [REGFILE_WORD_W-1:0] mux_word;
    logic [REGFILE_WORD_W-1:0] sel_word;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            buf_q   <= buf_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        buf_d   = buf_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    buf_d   = snap_flat;
                    idx_d   = '0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (out_ready) begin
                    // Index parks on the final word instead of wrapping.
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_FINISH;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Word selection
    // ------------------------------------------------------------------
    regfile_word_mux #(
        .REG_FILE_SIZE (REG_FILE_SIZE),
        .IDX_W         (IDX_W)
    ) u_word_mux (
        .flat_i  (buf_q),
        .index_i (idx_q),
        .word_o  (mux_word)
    );

`ifdef REGFILE_DUMP_CHECKSUM_EN
    logic [REGFILE_WORD_W-1:0] xsum;

    always_comb begin
        xsum = '0;
        for (int i = 0; i < REG_FILE_SIZE; i++) begin
            xsum = xsum ^ buf_q[i*REGFILE_WORD_W +: REGFILE_WORD_W];
        end
    end

    assign sel_word = (idx_q == LAST_IDX) ? xsum : mux_word;
`else
    assign sel_word = mux_word;
`endif

    // ------------------------------------------------------------------
    // Outputs: all decoded from reset-cleared state, so reset zeroes them
    // without waiting for an edge. Gating with in_send keeps them at 0
    // outside a dump.
    // ------------------------------------------------------------------
    assign in_send   = (state_q == ST_SEND);
    assign at_last   = (idx_q == LAST_IDX);
    assign out_valid = in_send;
    assign busy      = in_send;
    assign done      = (state_q == ST_FINISH);
    assign out_index = in_send ? idx_q : '0;
    assign out_last  = in_send && at_last;
    assign out_data  = in_send ? sel_word : '0;

endmodule

// File: doc/regfile_dump.md
REGFILE_DUMP -- requirements
Module: regfile_dump

Interface
REQ-001 SHALL have parameter REG_FILE_SIZE, default 8: number of 32-bit registers in the snapshot; legal range 2..64.
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port start, input, 1: request a dump of snap_flat.
REQ-005 SHALL have port snap_flat, input, 32*REG_FILE_SIZE: flat register snapshot; word i is at bits [i*32 +: 32].
REQ-006 SHALL have port out_ready, input, 1: sink accepts out_data this cycle.
REQ-007 SHALL have port out_valid, output, 1: out_data/out_index/out_last are valid.
REQ-008 SHALL have port out_data, output, 32: current word.
REQ-009 SHALL have port out_index, output, $clog2(REG_FILE_SIZE)+1: index of the current word.
REQ-010 SHALL have port out_last, output, 1: current word is the final word of the dump.
REQ-011 SHALL have port busy, output, 1: a dump is in progress.
REQ-012 SHALL have port done, output, 1: one-cycle pulse after the final word is accepted.

Function
REQ-013 SHALL implement a 3-state FSM: IDLE, SEND, FINISH.
REQ-014 In IDLE, start=1 SHALL copy all of snap_flat into an internal buffer, set index to 0, and go to SEND on the same edge.
REQ-015 Later changes on snap_flat SHALL NOT affect the words of a dump in progress.
REQ-016 start SHALL be ignored in SEND and FINISH; no queuing and no restart.
REQ-017 In SEND, out_valid SHALL be 1.
REQ-018 In SEND, out_data SHALL be the buffered word at out_index.
REQ-019 The first word SHALL appear one cycle after start is sampled.
REQ-020 A handshake is out_valid && out_ready; each handshake SHALL advance the index by exactly 1.
REQ-021 While out_valid && !out_ready, out_data, out_index and out_last SHALL hold stable.
REQ-022 out_last SHALL be 1 only while the final word is presented.
REQ-023 A handshake on the final word SHALL move the FSM to FINISH.
REQ-024 In FINISH, done=1 and busy=0 for exactly one cycle; then the FSM SHALL go to IDLE.
REQ-025 start asserted during FINISH SHALL be ignored.
REQ-026 busy SHALL be 1 exactly while in SEND.
REQ-027 With out_ready held at 1, a dump SHALL take REG_FILE_SIZE cycles in SEND, one word per cycle with no bubbles.
REQ-028 The index counter SHALL NOT wrap past the final word.

Reset
REQ-029 Asserting reset SHALL immediately, without waiting for a clock edge, force the FSM to IDLE.
REQ-030 Asserting reset SHALL immediately clear to 0: out_valid, out_data, out_index, out_last, busy, done and the internal buffer.
REQ-031 Reset mid-dump SHALL abort the dump, with no done pulse.
REQ-032 The first start sampled after reset deasserts SHALL be honoured normally.

Configuration
REQ-033 With REGFILE_DUMP_CHECKSUM_EN defined, the block SHALL append one extra word after word REG_FILE_SIZE-1.
REQ-034 The extra word SHALL be the XOR of all buffered words, presented at out_index = REG_FILE_SIZE.
REQ-035 With REGFILE_DUMP_CHECKSUM_EN defined, out_last SHALL be asserted only on the checksum word.
REQ-036 With REGFILE_DUMP_CHECKSUM_EN defined, SEND SHALL take REG_FILE_SIZE+1 handshakes.
REQ-037 Without REGFILE_DUMP_CHECKSUM_EN, no checksum logic SHALL exist and out_last SHALL mark word REG_FILE_SIZE-1.

Structure
REQ-038 A shared package regfile_pkg SHALL hold: REGFILE_WORD_W=32, the FSM state enum type, and the index-width function.
REQ-039 The word-select multiplexer SHALL be a sub-module named regfile_word_mux.
REQ-040 regfile_word_mux SHALL be purely combinational, with inputs flat buffer and index, and output a 32-bit word.

Verification
REQ-041 N=4, snap={4,3,2,1} (word0=1), start pulse, out_ready=1 -> words 1,2,3,4 on consecutive cycles; out_last with word 4; done pulses the next cycle.
REQ-042 out_ready toggled 1,0,0,1,... -> every word is held stable while stalled, none dropped or duplicated, indices 0..3 in order.
REQ-043 snap_flat changed to all 0xFFFFFFFF one cycle after start -> the original words are still output.
REQ-044 start pulsed while busy and during the done cycle -> exactly one dump and one done pulse.
REQ-045 reset asserted after the second handshake -> outputs go to 0 immediately, no done; the next start dumps from index 0.
REQ-046 REGFILE_DUMP_CHECKSUM_EN, snap={0xF0,0x0F,0xAA,0x55} -> a 5th word 0x00 at index 4, carrying out_last.
